// File: rtl/timing_decoder_pkg.sv
// Shared constants for the timing decoder: operating-mode encodings.
package timing_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SEQ    = 1'b1
  } mode_e;

endpackage

// File: rtl/timing_decoder_onehot.sv
// Purely combinational one-hot decoder; holds no state.
module decoder_onehot #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] out
);

  // Drive exactly one bit, selected by sel.
  always_comb begin
    out      = '0;
    out[sel] = 1'b1;
  end

endmodule

// File: rtl/timing_decoder.sv
// Timing decoder: direct one-hot decode of sel, or a free-running sequence
// 0..last. Optional macro TIMING_DECODER_WRAP_PULSE_EN adds a one-cycle
// 'wrap' pulse after each sequence advance that returns count to zero.
module timing_decoder
  import timing_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr,
  input  logic [SEL_W-1:0] last,
`ifdef TIMING_DECODER_WRAP_PULSE_EN
  output logic             wrap,
`endif
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] count
);

  logic             active;
  logic [SEL_W-1:0] count_nxt;
  logic [OUT_W-1:0] dec;
`ifdef TIMING_DECODER_WRAP_PULSE_EN
  logic             wrap_nxt;
`endif

  decoder_onehot #(.SEL_W(SEL_W)) u_dec (
    .sel (count),
    .out (dec)
  );

  // Next count: clear wins, then mode-specific update, otherwise hold.
  always_comb begin
    count_nxt = count;
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    wrap_nxt  = 1'b0;
`endif
    if (clr) begin
      count_nxt = '0;
    end else if (mode == MODE_SEQ) begin
      // Advance only once output is already active, so T0 is shown first.
      if (en && active) begin
        if (count >= last) begin
          count_nxt = '0;
`ifdef TIMING_DECODER_WRAP_PULSE_EN
          wrap_nxt  = 1'b1;
`endif
        end else begin
          count_nxt = count + SEL_W'(1);
        end
      end
    end else if (en) begin
      count_nxt = sel;
    end
  end

  // State registers; active simply tracks en with one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
`ifdef TIMING_DECODER_WRAP_PULSE_EN
      wrap   <= 1'b0;
`endif
    end else begin
      count  <= count_nxt;
      active <= en;
`ifdef TIMING_DECODER_WRAP_PULSE_EN
      wrap   <= wrap_nxt;
`endif
    end
  end

  // Output is the decoded count, blanked while inactive.
  always_comb begin
    out = active ? dec : '0;
  end

endmodule

// File: tb/tb_timing_decoder.sv
// Directed self-checking bench for timing_decoder (SEL_W = 3 and SEL_W = 4).
module tb_timing_decoder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        en3, mode3, clr3;
  logic [2:0]  sel3, last3;
  logic [7:0]  out3;
  logic [2:0]  count3;

  logic        en4, mode4, clr4;
  logic [3:0]  sel4, last4;
  logic [15:0] out4;
  logic [3:0]  count4;

`ifdef TIMING_DECODER_WRAP_PULSE_EN
  logic        wrap3, wrap4;
`endif

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timing_decoder #(.SEL_W(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en3),
    .mode  (mode3),
    .sel   (sel3),
    .clr   (clr3),
    .last  (last3),
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    .wrap  (wrap3),
`endif
    .out   (out3),
    .count (count3)
  );

  timing_decoder #(.SEL_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en4),
    .mode  (mode4),
    .sel   (sel4),
    .clr   (clr4),
    .last  (last4),
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    .wrap  (wrap4),
`endif
    .out   (out4),
    .count (count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en3 = 1'b1; mode3 = 1'b1; clr3 = 1'b0; sel3 = 3'd0; last3 = 3'd3;
    en4 = 1'b0; mode4 = 1'b0; clr4 = 1'b0; sel4 = 4'd0; last4 = 4'd0;
    #12;
    check("rst_out", 32'(out3), 32'h00);
    check("rst_count", 32'(count3), 32'd0);
    step();
    rst_n = 1'b1;

    // Sequence 0..3 with en held high from reset.
    step(); check("seq_t0", 32'(out3), 32'h01);
    step(); check("seq_t1", 32'(out3), 32'h02);
    step(); check("seq_t2", 32'(out3), 32'h04);
    step(); check("seq_t3", 32'(out3), 32'h08);
    step(); check("seq_wrap_out", 32'(out3), 32'h01);
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    check("seq_wrap_pulse", 32'(wrap3), 32'd1);
`endif
    step(); check("seq_again_t1", 32'(out3), 32'h02);
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    check("seq_wrap_drop", 32'(wrap3), 32'd0);
`endif
    step();
    step(); check("seq_cnt3", 32'(count3), 32'd3);

    // Asynchronous reset mid-sequence, checked before any clock edge.
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out3), 32'h00);
    check("arst_count", 32'(count3), 32'd0);
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    check("arst_wrap", 32'(wrap3), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step(); check("restart_t0", 32'(out3), 32'h01);
    step();
    step(); check("pre_clr_cnt2", 32'(count3), 32'd2);

    // Clear with and without enable.
    clr3 = 1'b1;
    step(); check("clr_en_out", 32'(out3), 32'h01);
    en3 = 1'b0;
    step(); check("clr_dis_out", 32'(out3), 32'h00);
    check("clr_dis_count", 32'(count3), 32'd0);
    clr3 = 1'b0;

    // Direct decode.
    mode3 = 1'b0; en3 = 1'b1; sel3 = 3'd5;
    step(); check("dir_out", 32'(out3), 32'h20);
    check("dir_count", 32'(count3), 32'd5);
    en3 = 1'b0;
    step(); check("dir_off_out", 32'(out3), 32'h00);
    check("dir_off_count", 32'(count3), 32'd5);

    // Mode switch carries count 5; lowering last forces a return to 0.
    mode3 = 1'b1; en3 = 1'b1; last3 = 3'd7;
    step(); check("carry_out", 32'(out3), 32'h20);
    last3 = 3'd2;
    step(); check("lower_last_cnt", 32'(count3), 32'd0);
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    check("lower_last_wrap", 32'(wrap3), 32'd1);
`endif
    last3 = 3'd0;
    step(); check("last0_a", 32'(out3), 32'h01);
    step(); check("last0_b", 32'(out3), 32'h01);

    // Freeze while disabled, resume from frozen count.
    last3 = 3'd7;
    step(); check("run_t1", 32'(out3), 32'h02);
    step(); check("run_t2", 32'(out3), 32'h04);
    en3 = 1'b0;
    step(); check("freeze_out", 32'(out3), 32'h00);
    step(); check("freeze_count", 32'(count3), 32'd2);
    en3 = 1'b1;
    step(); check("resume_out", 32'(out3), 32'h04);
    step(); check("resume_next", 32'(out3), 32'h08);

    // SEL_W = 4: top select value and wrap from 15.
    en4 = 1'b1; mode4 = 1'b0; sel4 = 4'd15;
    step(); check("w4_dir_out", 32'(out4), 32'h8000);
    check("w4_dir_count", 32'(count4), 32'd15);
    mode4 = 1'b1; last4 = 4'd15;
    step(); check("w4_wrap_out", 32'(out4), 32'h0001);
    check("w4_wrap_count", 32'(count4), 32'd0);
`ifdef TIMING_DECODER_WRAP_PULSE_EN
    check("w4_wrap_pulse", 32'(wrap4), 32'd1);
`endif
    step(); check("w4_next", 32'(out4), 32'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/timing_decoder.md
TIMING_DECODER -- requirements
Module: timing_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select/count width in bits, legal range 1..6.
REQ-002 SHALL have derived localparam OUT_W = 2**SEL_W: one-hot output width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port en  input  1  enable; gates output activity and count update.
REQ-006 SHALL have port mode  input  1  operating mode: 0 = direct decode, 1 = sequence.
REQ-007 SHALL have port sel  input  SEL_W  direct-mode select value.
REQ-008 SHALL have port clr  input  1  synchronous clear of the count.
REQ-009 SHALL have port last  input  SEL_W  sequence-mode terminal count.
REQ-010 SHALL have port out  output  OUT_W  registered one-hot (or all-zero) decode.
REQ-011 SHALL have port count  output  SEL_W  current internal count/select register.

Function
REQ-012 SHALL hold two state elements: count register (SEL_W bits) and active flag (1 bit).
REQ-013 SHALL drive out = onehot(count) when active = 1, and all zeros when active = 0.
REQ-014 SHALL set active <= en on every clock edge, giving one-cycle latency from en to out.
REQ-015 Priority on each edge SHALL be: clr, then mode-specific update, then hold.
REQ-016 When clr = 1, the block SHALL set count <= 0 regardless of mode or en; active still follows en.
REQ-017 In direct mode with en = 1, the block SHALL set count <= sel, so out = onehot(sel) one cycle later.
REQ-018 In direct mode with en = 0, count SHALL hold and out SHALL read zero from the next cycle.
REQ-019 In sequence mode, count SHALL advance only when en = 1 and active = 1, so the first active cycle presents the current count (T0 after reset or clr).
REQ-020 When count advances, next count SHALL be 0 if count >= last, else count + 1; wrap-around SHALL not exceed last.
REQ-021 In sequence mode with last = 0, count SHALL stay at 0 and out SHALL remain onehot(0) while enabled.
REQ-022 Lowering last below the current count mid-run SHALL return count to 0 on the next advance.
REQ-023 In sequence mode with en = 0, count SHALL freeze and out SHALL go zero; re-enabling SHALL resume from the frozen count.
REQ-024 A mode change SHALL take effect on the next edge; count SHALL carry over unchanged.

Reset
REQ-025 While rst_n = 0, the block SHALL immediately force count = 0, active = 0 and out = 0 (and wrap = 0 when present).
REQ-026 Reset assertion mid-sequence SHALL abandon the sequence; after release the sequence SHALL restart at T0.

Configuration
REQ-027 Macro TIMING_DECODER_WRAP_PULSE_EN SHALL add output wrap  output  1: a registered pulse, high for exactly one cycle following each sequence-mode advance that returns count to 0 (including via REQ-022), and never asserted on clr or in direct mode.
REQ-028 Without TIMING_DECODER_WRAP_PULSE_EN, the wrap port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package timing_decoder_pkg SHALL hold the mode constants MODE_DIRECT = 1'b0 and MODE_SEQ = 1'b1.
REQ-030 One-hot decode SHALL be a sub-module decoder_onehot (parameter SEL_W, purely combinational, input SEL_W, output 2**SEL_W), instantiated once.
REQ-031 All registers SHALL be in timing_decoder; decoder_onehot SHALL contain no state.

Verification
REQ-032 Reset: assert rst_n = 0 mid-sequence at count = 3 -> out = 0, count = 0 and wrap = 0 without waiting for a clock edge.
REQ-033 Direct, SEL_W = 3: en = 1, sel = 5 -> next cycle out = 8'b0010_0000, count = 5; then en = 0 -> next cycle out = 0, count = 5.
REQ-034 Sequence, last = 3, en held at 1 from reset -> out = 0x01, 0x02, 0x04, 0x08, 0x01 on successive cycles; wrap high on the cycle out returns to 0x01.
REQ-035 Clear: sequence at count = 2, clr = 1 with en = 1 -> next out = 0x01; clr = 1 with en = 0 -> out = 0, count = 0.
REQ-036 Boundary: last changed from 7 to 2 while count = 5 -> next count = 0 with wrap pulse; then last = 0 -> out stays 0x01.
REQ-037 Width: SEL_W = 4, direct mode, sel = 15 -> out = 16'h8000; sequence with last = 15 wraps from 15 to 0.
